// File: rtl/dii_arb_pkg.sv
// Shared types and constants for the DII packet arbiter.
// Holds the arbiter FSM state type and the statistics counter width.
package dii_arb_pkg;

  typedef enum logic [0:0] {
    IDLE,
    BUSY
  } arb_state_t;

  localparam int STAT_W = 16;

endpackage

// File: rtl/dii_rr_select.sv
// Round-robin request selector, purely combinational.
// Returns the first requester strictly after ptr, searching modulo PORTS.
module dii_rr_select
  import dii_arb_pkg::*;
#(
  parameter int PORTS = 2,
  parameter int IW    = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic [PORTS-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    next,
  output logic             any
);

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    next = ptr;
    any  = |req;
    for (int i = PORTS; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % PORTS]) begin
        next = IW'((int'(ptr) + i) % PORTS);
      end
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one DII output channel.
// Optional per-port packet counters when DII_ARB_STATS_EN is defined.
module dii_packet_arbiter
  import dii_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PORTS = 2,
  localparam int IW   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_first,
  input  logic [PORTS-1:0]       in_last,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS-1:0]       in_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_first,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IW-1:0]          grant,
`ifdef DII_ARB_STATS_EN
  output logic [PORTS*STAT_W-1:0] pkt_count,
`endif
  output logic                   busy
);

  arb_state_t    state;
  logic [IW-1:0] next;
  logic          any;
  logic          done;

  dii_rr_select #(
    .PORTS (PORTS),
    .IW    (IW)
  ) u_sel (
    .req  (in_valid),
    .ptr  (grant),
    .next (next),
    .any  (any)
  );

  assign busy = (state == BUSY);
  assign done = out_valid & out_ready & out_last;

  // Forward the granted port while locked; everything idles to zero otherwise.
  always_comb begin
    out_data  = '0;
    out_first = 1'b0;
    out_last  = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    if (state == BUSY) begin
      out_data  = in_data[int'(grant)*WIDTH +: WIDTH];
      out_first = in_first[grant];
      out_last  = in_last[grant];
      out_valid = in_valid[grant];
      in_ready  = out_ready ? (PORTS'(1) << grant) : '0;
    end
  end

  // Arbitrate in IDLE, hold the lock until the last beat transfers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      grant <= IW'(PORTS - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant <= next;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DII_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [PORTS];

  // Count completed packets per port; wraps naturally at the top.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PORTS; i++) cnt[i] <= '0;
    end else if (done) begin
      cnt[grant] <= cnt[grant] + 1'b1;
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_cnt
    assign pkt_count[g*STAT_W +: STAT_W] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed self-checking bench for dii_packet_arbiter.
// Covers reset, locking, fairness, stalls, async reset and optional stats.
module tb_dii_packet_arbiter;

  localparam int WIDTH = 16;
  localparam int PORTS = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [2*WIDTH-1:0] in_data = '0;
  logic [1:0]        in_first = '0;
  logic [1:0]        in_last = '0;
  logic [1:0]        in_valid = '0;
  logic [1:0]        in_ready;
  logic [WIDTH-1:0]  out_data;
  logic              out_first;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [0:0]        grant;
  logic              busy;
`ifdef DII_ARB_STATS_EN
  logic [2*16-1:0]   pkt_count;
`endif

  int errors = 0;
  int checks = 0;

  dii_packet_arbiter #(
    .WIDTH (WIDTH),
    .PORTS (PORTS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
`ifdef DII_ARB_STATS_EN
    .pkt_count (pkt_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and leave time for inputs to be driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #3;
  endtask

  task automatic drv(input int p, input logic [15:0] d, input logic f,
                     input logic l, input logic v);
    in_data[p*WIDTH +: WIDTH] = d;
    in_first[p] = f;
    in_last[p]  = l;
    in_valid[p] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = '0;
    in_first = '0;
    in_last = '0;
    in_data = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    out_ready = 1'b0;
    do_reset();

    // Reset state
    settle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);

    // Test 1: three-beat packet on port 0
    step();
    out_ready = 1'b1;
    drv(0, 16'hA001, 1'b1, 1'b0, 1'b1);
    settle();
    chk("t1_idle_valid", 32'(out_valid), 32'd0);
    chk("t1_idle_ready", 32'(in_ready), 32'd0);
    step();
    settle();
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_b0_valid", 32'(out_valid), 32'd1);
    chk("t1_b0_data", 32'(out_data), 32'hA001);
    chk("t1_b0_first", 32'(out_first), 32'd1);
    chk("t1_b0_ready", 32'(in_ready), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    step();
    drv(0, 16'hA002, 1'b0, 1'b0, 1'b1);
    settle();
    chk("t1_b1_data", 32'(out_data), 32'hA002);
    step();
    drv(0, 16'hA003, 1'b0, 1'b1, 1'b1);
    settle();
    chk("t1_b2_last", 32'(out_last), 32'd1);
    chk("t1_b2_busy", 32'(busy), 32'd1);
    step();
    drv(0, 16'h0000, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t1_end_busy", 32'(busy), 32'd0);
    chk("t1_end_valid", 32'(out_valid), 32'd0);
    chk("t1_end_grant", 32'(grant), 32'd0);

    // Test 2: both ports always valid with two-beat packets
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drv(0, 16'h1000, 1'b1, 1'b0, 1'b1);
      drv(1, 16'h2000, 1'b1, 1'b0, 1'b1);
      settle();
      chk("t2_idle_valid", 32'(out_valid), 32'd0);
      step();
      settle();
      chk("t2_grant", 32'(grant), 32'(k % 2));
      chk("t2_b0_data", 32'(out_data), (k % 2 == 0) ? 32'h1000 : 32'h2000);
      chk("t2_b0_ready", 32'(in_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      if (k % 2 == 0) drv(0, 16'h1001, 1'b0, 1'b1, 1'b1);
      else drv(1, 16'h2001, 1'b0, 1'b1, 1'b1);
      settle();
      chk("t2_b1_data", 32'(out_data), (k % 2 == 0) ? 32'h1001 : 32'h2001);
      chk("t2_b1_last", 32'(out_last), 32'd1);
      step();
    end

    // Test 3: port 1 packet under backpressure
    do_reset();
    out_ready = 1'b1;
    drv(1, 16'hB000, 1'b1, 1'b0, 1'b1);
    step();
    settle();
    chk("t3_grant", 32'(grant), 32'd1);
    chk("t3_b0_ready", 32'(in_ready), 32'd2);
    step();
    drv(1, 16'hB001, 1'b0, 1'b0, 1'b1);
    out_ready = 1'b0;
    settle();
    chk("t3_stall_ready", 32'(in_ready), 32'd0);
    chk("t3_stall_data", 32'(out_data), 32'hB001);
    step();
    settle();
    chk("t3_hold_data", 32'(out_data), 32'hB001);
    chk("t3_hold_busy", 32'(busy), 32'd1);
    #1;
    out_ready = 1'b1;
    #1;
    chk("t3_go_ready", 32'(in_ready), 32'd2);
    step();
    drv(1, 16'hB002, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    settle();
    chk("t3_last_stall", 32'(in_ready), 32'd0);
    step();
    out_ready = 1'b1;
    settle();
    chk("t3_last_ready", 32'(in_ready), 32'd2);
    chk("t3_last_data", 32'(out_data), 32'hB002);
    step();
    drv(1, 16'h0000, 1'b0, 1'b0, 1'b0);
    settle();
    chk("t3_end_busy", 32'(busy), 32'd0);

    // Test 4: back-to-back single-beat packets on port 0
    do_reset();
    out_ready = 1'b1;
    drv(0, 16'hC0C0, 1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t4_valid", 32'(out_valid), 32'(c % 2));
      if (c > 0) chk("t4_grant", 32'(grant), 32'd0);
      step();
    end
    drv(0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Test 5: reset dropped mid-packet
    do_reset();
    out_ready = 1'b1;
    drv(0, 16'hD000, 1'b1, 1'b0, 1'b1);
    step();
    step();
    drv(0, 16'hD001, 1'b0, 1'b0, 1'b1);
    step();
    drv(0, 16'hD002, 1'b0, 1'b0, 1'b1);
    settle();
    chk("t5_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(out_valid), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(in_ready), 32'd0);
    chk("t5_rst_grant", 32'(grant), 32'd1);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    step();
    rst = 1'b1;
    drv(0, 16'hE000, 1'b1, 1'b1, 1'b1);
    drv(1, 16'hE100, 1'b1, 1'b1, 1'b1);
    step();
    settle();
    chk("t5_next_grant", 32'(grant), 32'd0);
    chk("t5_next_data", 32'(out_data), 32'hE000);

`ifdef DII_ARB_STATS_EN
    // Packet counters: three single-beat packets on port 1
    do_reset();
    out_ready = 1'b1;
    drv(1, 16'hF000, 1'b1, 1'b1, 1'b1);
    settle();
    chk("st_rst", 32'(pkt_count), 32'd0);
    for (int n = 0; n < 6; n++) step();
    drv(1, 16'h0000, 1'b0, 1'b0, 1'b0);
    step();
    settle();
    chk("st_p1", 32'(pkt_count[31:16]), 32'd3);
    chk("st_p0", 32'(pkt_count[15:0]), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
